clock_timekeeper: RTL

- Time-of-day core sitting directly upstream of the 7-segment display stage.
- Keeps hours/minutes/seconds from a prescaled system clock and handles three-button time setting.
- Produces the display-stage inputs: packed 12-bit field pair `data_show`, the digit scan index `byte_status` (0,2,4,6), and the per-digit enable mask `segment_byte_control`, including blink during setting.

---
 rtl/clock_timekeeper.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/clock_timekeeper.sv
// Time-of-day core: h/m/s counting, three-button time setting and 7-segment scan/blink control.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the tens digit of the high field below 10.
`timescale 1ns / 1ps

module clock_timekeeper #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_sel,
  input  logic        btn_inc,
  output logic [11:0] data_show,
  output logic [2:0]  byte_status,
  output logic [3:0]  segment_byte_control,
  output logic        sec_pulse,
  output logic        set_active
);

  localparam int unsigned PreW  = $clog2(TICK_DIV);
  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PreW-1:0]  PreMax  = PreW'(TICK_DIV - 1);
  localparam logic [PreW-1:0]  PreHalf = PreW'(TICK_DIV / 2);
  localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {StRun, StSetHour, StSetMin} state_e;

  state_e           state_q, state_d;
  logic             view_q, view_d;  // 0: HM, 1: MS
  logic [5:0]       hours_q, hours_d;
  logic [5:0]       minutes_q, minutes_d;
  logic [5:0]       seconds_q, seconds_d;
  logic [PreW-1:0]  presc_q, presc_d;
  logic [PreW-1:0]  blink_q, blink_d;
  logic [ScanW-1:0] scan_q, scan_d;
  logic [1:0]       digit_q, digit_d;
  logic             sec_pulse_q, sec_pulse_d;
  // Button bit order: [0] mode, [1] sel, [2] inc.
  logic [2:0]       s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;

  logic [2:0] btn_edge;
  logic       mode_edge, sel_edge, inc_edge, tick, blink_off;

  always_comb begin
    s1_d = {btn_inc, btn_sel, btn_mode};
    s2_d = s1_q;
    s3_d = s2_q;
  end

  assign btn_edge  = s2_q & ~s3_q;
  assign mode_edge = btn_edge[0];
  assign sel_edge  = btn_edge[1];
  assign inc_edge  = btn_edge[2] & ~btn_edge[0];  // mode wins over a coincident inc
  assign tick      = (state_q == StRun) && (presc_q == PreMax);

  always_comb begin
    state_d     = state_q;
    view_d      = view_q;
    hours_d     = hours_q;
    minutes_d   = minutes_q;
    seconds_d   = seconds_q;
    presc_d     = presc_q;
    sec_pulse_d = 1'b0;

    if (state_q == StRun) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    if (tick) begin
      sec_pulse_d = 1'b1;
      if (seconds_q == 6'd59) begin
        seconds_d = 6'd0;
        if (minutes_q == 6'd59) begin
          minutes_d = 6'd0;
          hours_d   = (hours_q == 6'd23) ? 6'd0 : hours_q + 6'd1;
        end else begin
          minutes_d = minutes_q + 6'd1;
        end
      end else begin
        seconds_d = seconds_q + 6'd1;
      end
    end

    unique case (state_q)
      StRun: begin
        if (mode_edge) begin
          state_d = StSetHour;
          presc_d = '0;
        end
      end
      StSetHour: begin
        if (mode_edge) begin
          state_d = StSetMin;
        end else if (inc_edge) begin
          hours_d = (hours_q == 6'd23) ? 6'd0 : hours_q + 6'd1;
        end
      end
      StSetMin: begin
        if (mode_edge) begin
          state_d   = StRun;
          seconds_d = 6'd0;
          presc_d   = '0;
        end else if (inc_edge) begin
          minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
        end
      end
      default: state_d = StRun;
    endcase

    if (sel_edge) begin
      view_d = ~view_q;
    end
  end

  // Blink phase restarts on every state change so each SET state opens visible.
  always_comb begin
    if (state_d != state_q) begin
      blink_d = '0;
    end else begin
      blink_d = (blink_q == PreMax) ? '0 : blink_q + 1'b1;
    end
    scan_d  = (scan_q == ScanMax) ? '0 : scan_q + 1'b1;
    digit_d = (scan_q == ScanMax) ? digit_q + 2'd1 : digit_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      view_q      <= 1'b0;
      hours_q     <= 6'd0;
      minutes_q   <= 6'd0;
      seconds_q   <= 6'd0;
      presc_q     <= '0;
      blink_q     <= '0;
      scan_q      <= '0;
      digit_q     <= 2'd0;
      sec_pulse_q <= 1'b0;
      s1_q        <= 3'b000;
      s2_q        <= 3'b000;
      s3_q        <= 3'b000;
    end else begin
      state_q     <= state_d;
      view_q      <= view_d;
      hours_q     <= hours_d;
      minutes_q   <= minutes_d;
      seconds_q   <= seconds_d;
      presc_q     <= presc_d;
      blink_q     <= blink_d;
      scan_q      <= scan_d;
      digit_q     <= digit_d;
      sec_pulse_q <= sec_pulse_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
    end
  end

  assign blink_off = (blink_q >= PreHalf);

  always_comb begin
    if ((state_q == StRun) && view_q) begin
      data_show = {minutes_q, seconds_q};
    end else begin
      data_show = {hours_q, minutes_q};
    end

    segment_byte_control = 4'b1111;
    if (blink_off && (state_q == StSetHour)) begin
      segment_byte_control[3:2] = 2'b00;
    end
    if (blink_off && (state_q == StSetMin)) begin
      segment_byte_control[1:0] = 2'b00;
    end
`ifdef LEADING_ZERO_BLANK_EN
    if (data_show[11:6] < 6'd10) begin
      segment_byte_control[3] = 1'b0;
    end
`endif
  end

  assign byte_status = {digit_q, 1'b0};
  assign sec_pulse   = sec_pulse_q;
  assign set_active  = (state_q != StRun);

endmodule
